// File: rtl/chunked_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared CHUNK-bit fast adder, one chunk per clock, LSB first.
// Latency N=WIDTH/CHUNK edges from accept to done; ready_out only in IDLE, start_in ignored otherwise. Option: CHUNKED_ADD_EARLY_EXIT_EN.

module chunked_add_fast_adder #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            c_in,
  output logic [BITS-1:0] sum_out,
  output logic            gg_out,
  output logic            pg_out
);
  logic [BITS-1:0] g, p;
  logic            cy, gc;

  assign g      = a & b;
  assign p      = a ^ b;
  assign pg_out = &p;

  always_comb begin
    sum_out = '0;
    cy      = c_in;
    gc      = 1'b0;
    for (int k = 0; k < BITS; k++) begin
      sum_out[k] = p[k] ^ cy;
      cy         = g[k] | (p[k] & cy);
      gc         = g[k] | (p[k] & gc);
    end
    gg_out = gc;
  end
endmodule

module chunked_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             v_out
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("chunked_add_sequencer: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [1:0]       state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic [CHUNK-1:0] a_chk, b_chk, chk_sum;
  logic             gg, pg, carry_nxt, last_chunk, finish, msb_cin;

  // Constant-index mux keeps the chunk select a plain case per chunk.
  always_comb begin
    a_chk   = '0;
    b_chk   = '0;
    acc_nxt = acc_q;
    for (int k = 0; k < N; k++) begin
      if (int'(idx_q) == k) begin
        a_chk                      = a_q[k*CHUNK +: CHUNK];
        b_chk                      = b_q[k*CHUNK +: CHUNK];
        acc_nxt[k*CHUNK +: CHUNK]  = chk_sum;
      end
    end
  end

  chunked_add_fast_adder #(.BITS(CHUNK)) u_fast_adder (
    .a      (a_chk),
    .b      (b_chk),
    .c_in   (carry_q),
    .sum_out(chk_sum),
    .gg_out (gg),
    .pg_out (pg)
  );

  assign carry_nxt  = gg | (pg & carry_q);
  assign last_chunk = (int'(idx_q) == N - 1);
  // Carry into the MSB falls out of the sum bit and the two operand bits.
  assign msb_cin    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_nxt[WIDTH-1];

`ifdef CHUNKED_ADD_EARLY_EXIT_EN
  logic rest_zero;
  always_comb begin
    rest_zero = 1'b1;
    for (int k = 0; k < N; k++) begin
      if ((k > int'(idx_q)) && ((a_q[k*CHUNK +: CHUNK] | b_q[k*CHUNK +: CHUNK]) != '0))
        rest_zero = 1'b0;
    end
  end
  assign finish = last_chunk | (rest_zero & ~carry_nxt);
`else
  assign finish = last_chunk;
`endif

  assign ready_out = (state_q == S_IDLE);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sum_out  <= '0;
      c_out    <= 1'b0;
      v_out    <= 1'b0;
      done_out <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= carry_nxt;
          if (finish) begin
            sum_out  <= acc_nxt;
            c_out    <= carry_nxt;
            v_out    <= carry_nxt ^ msb_cin;
            done_out <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          done_out <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Scoreboard bench for chunked_add_sequencer (WIDTH=16, CHUNK=4): driver pushes expectations, monitor pops on done_out.
module tb_chunked_add_sequencer;
  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        start_in = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        c_in = 1'b0;
  logic        ready_out, done_out, c_out, v_out;
  logic [15:0] sum_out;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

`ifdef CHUNKED_ADD_EARLY_EXIT_EN
  localparam int EE_LAT = 1;
`else
  localparam int EE_LAT = 4;
`endif

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          cy;
  } exp_t;
  exp_t q[$];

  chunked_add_sequencer #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .ready_out(ready_out),
    .done_out (done_out),
    .sum_out  (sum_out),
    .c_out    (c_out),
    .v_out    (v_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !ready_out; i++) step();
    chk("ready_wait", 32'(ready_out), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input int cy);
    exp_t e;
    logic [16:0] s;
    s    = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.s  = s[15:0];
    e.c  = s[16];
    e.v  = (a[15] == b[15]) && (s[15] != a[15]);
    e.cy = cy;
    return e;
  endfunction

  // Called at posedge+#1 while idle; E0 is the next posedge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, input int lat);
    wait_ready();
    a_in = a; b_in = b; c_in = c; start_in = 1'b1;
    q.push_back(model(a, b, c, cyc + 1 + lat));
    step();
    start_in = 1'b0;
    a_in = ~a; b_in = ~b; c_in = ~c;
    chk("ready_after_accept", 32'(ready_out), 32'd0);
    wait_drain();
    chk("ready_after_done", 32'(ready_out), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk_in);
    chk({tag, "_ready"}, 32'(ready_out), 32'd1);
    chk({tag, "_done"},  32'(done_out),  32'd0);
    chk({tag, "_sum"},   32'(sum_out),   32'd0);
    chk({tag, "_cv"},    32'({c_out, v_out}), 32'd0);
  endtask

  // Monitor: pops on done_out, otherwise checks that results are held.
  initial begin
    logic [17:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk_in);
      if (reset_in) begin
        last = '0;
      end else if (done_out) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done_out), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum_out), 32'(e.s));
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("v_out", 32'(v_out), 32'(e.v));
          chk("done_cycle", 32'(cyc), 32'(e.cy));
          chk("ready_in_done", 32'(ready_out), 32'd0);
        end
        last = {sum_out, c_out, v_out};
      end else begin
        chk("result_hold", 32'({sum_out, c_out, v_out}), 32'(last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_reset_vals("reset_init");
    step();
    reset_in = 1'b0;
    step();

    do_op(16'h1234, 16'h0001, 1'b0, 4);
    do_op(16'hFFFF, 16'h0000, 1'b1, 4);

    // Reset while idle with a non-zero result on the outputs.
    do_op(16'h7FFF, 16'h0001, 1'b0, 4);
    reset_in = 1'b1;
    chk_reset_vals("reset_idle");
    step();
    reset_in = 1'b0;
    step();

    do_op(16'h0003, 16'h0004, 1'b0, EE_LAT);

    // start_in held high: second accept only at E6.
    wait_ready();
    a_in = 16'h0F0F; b_in = 16'h00F1; c_in = 1'b0; start_in = 1'b1;
    q.push_back(model(16'h0F0F, 16'h00F1, 1'b0, cyc + 1 + 4));
    q.push_back(model(16'h0F0F, 16'h00F1, 1'b0, cyc + 1 + 6 + 4));
    wait_drain();
    start_in = 1'b0;
    chk("ready_after_hold", 32'(ready_out), 32'd1);
    step();
    step();

    // Reset after E2 of a running operation; no done may follow.
    wait_ready();
    a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b0; start_in = 1'b1;
    step();
    start_in = 1'b0;
    step();
    step();
    reset_in = 1'b1;
    chk_reset_vals("reset_run");
    step();
    reset_in = 1'b0;
    repeat (10) step();

    do_op(16'h0001, 16'h0002, 1'b0, EE_LAT);
    do_op(16'h8000, 16'h8000, 1'b0, 4);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chunked_add_sequencer.md
Name: chunked_add_sequencer

Overview:
- Multi-cycle WIDTH-bit adder built around one shared CHUNK-bit FastAdder instance, driven one chunk per clock from LSB to MSB.
- A registered group carry links the chunks.
- Gives the accumulator datapath a wide add without a wide carry-lookahead tree. Uses a start/ready/done handshake.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, width of the internal FastAdder (BITS); must be ≥1.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- start_in  input  1  request a new addition; accepted only while ready_out=1.
- a_in  input  WIDTH  operand A; sampled on the accepting edge.
- b_in  input  WIDTH  operand B; sampled on the accepting edge.
- c_in  input  1  carry-in; sampled on the accepting edge.
- ready_out  output  1  high only in IDLE.
- done_out  output  1  one-cycle pulse; result outputs valid from this cycle.
- sum_out  output  WIDTH  result; holds its value until the next completion.
- c_out  output  1  carry out of bit WIDTH-1.
- v_out  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- N = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - State → IDLE, chunk index → 0, carry register → 0.
  - Operand and accumulator registers → 0.
  - sum_out=0, c_out=0, v_out=0, done_out=0, ready_out=1.
  - The in-flight operation is discarded with no done_out pulse.
- IDLE, edge E0 with start_in=1:
  - Latch a_in, b_in, c_in; carry register ← c_in; index ← 0; → RUN.
  - start_in=0 keeps IDLE.
- RUN, chunk i at edge E(i+1):
  - Drive FastAdder with a[i*CHUNK +: CHUNK], b[i*CHUNK +: CHUNK], c_in=carry register.
  - Write sum_out of the adder into accumulator chunk i.
  - carry register ← gg_out | (pg_out & carry register).
  - Record the carry into the MSB when i=N-1; the top chunk's internal MSB carry is recomputed from the operand MSBs and the sum MSB.
  - index ← i+1.
- End of RUN, edge EN (after chunk N-1):
  - sum_out ← accumulator; c_out ← final carry; v_out ← final carry XOR carry into MSB.
  - done_out ← 1; → DONE.
- DONE:
  - One cycle only; at E(N+1) done_out ← 0 and state → IDLE (ready_out=1 from E(N+1)).
- Timing:
  - Accept-to-done latency is N edges. The next start is accepted at the earliest edge E(N+2).
- start_in while RUN/DONE: ignored, not queued. Input changes after E0 have no effect.
- Width and wrap rules:
  - sum_out = (a+b+c) mod 2^WIDTH.
  - The index counter needs clog2(N)+1 bits and never wraps past N-1.
- N=1: RUN lasts one cycle; behaviour is otherwise identical.
- sum_out, c_out and v_out change only at the completion edge (and at reset), never mid-operation.

Optional Feature:
- CHUNKED_ADD_EARLY_EXIT_EN defined:
  - Condition: at any RUN edge after chunk i is written, carry register (new value)=0 and all remaining chunks of A and B (i+1..N-1) are zero.
  - Then remaining accumulator chunks are 0, and completion happens at that edge: c_out=0, v_out=0, done_out pulse, → DONE.
  - Latency becomes i+1 edges.
- Not defined: always exactly N RUN cycles. Results are bit-identical in both builds; only latency differs.

Test Plan (WIDTH=16, CHUNK=4, N=4):
- Assert reset_in mid-idle and mid-RUN (after E2) → immediately ready_out=1, done_out=0, sum_out=0x0000, c_out=0, v_out=0; no later done_out pulse.
- a=0x1234, b=0x0001, c=0, start → done_out high in the cycle after E4 only; sum_out=0x1235, c_out=0, v_out=0; ready_out=1 from E5.
- a=0xFFFF, b=0x0000, c=1 (carry ripples through all chunks) → sum_out=0x0000, c_out=1, v_out=0 at E4.
- a=0x7FFF, b=0x0001, c=0 → sum_out=0x8000, c_out=0, v_out=1.
- Hold start_in=1 continuously with a=0x0F0F, b=0x00F1 → first result 0x1000 at E4; start re-accepted at E6; no accept during RUN/DONE; sum_out stable 0x1000 between completions.
- a=0x0003, b=0x0004, c=0 → sum_out=0x0007.
  - With CHUNKED_ADD_EARLY_EXIT_EN: done_out after E1.
  - Without it: done_out after E4.
